// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register index width,
// scoreboard entry layout and hazard FSM states.
package cpu_pkg;

    localparam int REG_W      = 4;
    localparam int STAGES_MAX = 6;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             load;
    } sb_entry_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/sb_shift.sv
// In-flight register-write scoreboard; entry 0 is youngest.
// A stalled cycle pushes a bubble, flush empties every entry.
module sb_shift
    import cpu_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   stall,
    input  sb_entry_t              ins,
    output sb_entry_t [STAGES-1:0] entries
);

    sb_entry_t [STAGES-1:0] entries_q;
    sb_entry_t [STAGES-1:0] entries_d;

    // Shift toward older stages; flush beats shift and load.
    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            entries_d = '0;
        end else begin
            for (int i = STAGES - 1; i >= 1; i--) begin
                entries_d[i] = entries_q[i-1];
            end
            entries_d[0] = stall ? sb_entry_t'('0) : ins;
        end
    end

    // Scoreboard register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign entries = entries_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode hazard detector: stalls IF/ID on in-flight writes,
// with saturating stall-cycle and stall-episode counters.
module hazard_stall_unit #(
    parameter int STAGES = 3,
    parameter int FWD    = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             id_write,
    input  logic [3:0]       id_writeReg,
    input  logic [3:0]       id_readReg0,
    input  logic [3:0]       id_readReg1,
    input  logic             id_immediate,
    input  logic             id_ReadMem,
    input  logic             id_WriteMem,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] stall_events
);

    import cpu_pkg::*;

    sb_entry_t [STAGES-1:0] sb;
    sb_entry_t              ins;
    logic                   use1;
    logic [STAGES-1:0]      match;
    logic [STAGES-1:0]      qual;
    logic                   hazard;

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] events_q, events_d;

    sb_shift #(
        .STAGES (STAGES)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .stall   (stall),
        .ins     (ins),
        .entries (sb)
    );

    // Source matching against every entry; with forwarding
    // only a load sitting in the youngest entry can hurt.
    always_comb begin
        ins.valid = id_write;
        ins.rd    = id_writeReg;
        ins.load  = id_ReadMem;
        use1      = !id_immediate || id_WriteMem;
        for (int e = 0; e < STAGES; e++) begin
            match[e] = sb[e].valid &&
                       ((sb[e].rd == id_readReg0) ||
                        (use1 && (sb[e].rd == id_readReg1)));
            qual[e]  = (FWD == 0) || ((e == 0) && sb[e].load);
        end
        hazard = |(match & qual);
        stall  = hazard && !flush;
        bubble = stall;
    end

    // FSM next state and saturating performance counters.
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        events_d = events_q;
        if (flush) begin
            state_d = ST_RUN;
        end else begin
            state_d = stall ? ST_STALL : ST_RUN;
        end
        if (stall && (cycles_q != '1)) begin
            cycles_d = cycles_q + 1'b1;
        end
        if (stall && (state_q == ST_RUN) && (events_q != '1)) begin
            events_d = events_q + 1'b1;
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            cycles_q <= '0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            events_q <= events_d;
        end
    end

    assign stall_cycles = cycles_q;
    assign stall_events = events_q;

endmodule
